// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multi-cycle accumulator-style CPU core.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   en_in        run enable, sampled in IDLE and WB
//   ins_req      fetch request, high for the whole FETCH state
//   addr         instruction address (PC)
//   ins          16-bit instruction word
//   ins_valid    RAM data valid, accepted only in FETCH
//   instr_done   one-cycle pulse in WB of every retired instruction
//   halted       high in HALT state
//   flag_z/n/c   status flags
//   dbg_sel      debug register select
//   dbg_data     combinational read of R[dbg_sel]
module cpu_core_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    output logic              ins_req,
    output logic [ADDR_W-1:0] addr,
    input  logic [15:0]       ins,
    input  logic              ins_valid,
    output logic              instr_done,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0] OP_MOVI = 4'h0;
    localparam logic [3:0] OP_MOVR = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_ADDR = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_SUBR = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_ANDR = 4'h7;
    localparam logic [3:0] OP_ORRI = 4'h8;
    localparam logic [3:0] OP_ORRR = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [4];
    logic              r_z;
    logic              r_n;
    logic              r_c;

    // Values computed in EXEC and committed in WB
    logic [DATA_W-1:0] r_res;
    logic              r_wr;
    logic              r_nz;
    logic              r_nn;
    logic              r_nc;

    logic [3:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_rsv;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_wr;
    logic              w_upd_zn;
    logic              w_nc;
    logic              w_nz;
    logic              w_nn;
    logic              w_take;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:10];
    assign w_rs  = r_ir[9:8];
    assign w_imm = DATA_W'(r_ir[7:0]);
    assign w_a   = r_regs[w_rd];
    assign w_rsv = r_regs[w_rs];

    // Odd opcodes take the register operand, even ones the immediate
    assign w_b    = w_op[0] ? w_rsv : w_imm;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_res    = '0;
        w_wr     = 1'b0;
        w_upd_zn = 1'b0;
        w_nc     = r_c;
        unique case (w_op)
            OP_MOVI, OP_MOVR: begin
                w_res    = w_b;
                w_wr     = 1'b1;
                w_upd_zn = 1'b1;
            end
            OP_ADDI, OP_ADDR: begin
                w_res    = w_sum[DATA_W-1:0];
                w_nc     = w_sum[DATA_W];
                w_wr     = 1'b1;
                w_upd_zn = 1'b1;
            end
            OP_SUBI, OP_SUBR: begin
                w_res    = w_diff[DATA_W-1:0];
                w_nc     = w_diff[DATA_W];
                w_wr     = 1'b1;
                w_upd_zn = 1'b1;
            end
            OP_ANDI, OP_ANDR: begin
                w_res    = w_a & w_b;
                w_nc     = 1'b0;
                w_wr     = 1'b1;
                w_upd_zn = 1'b1;
            end
            OP_ORRI, OP_ORRR: begin
                w_res    = w_a | w_b;
                w_nc     = 1'b0;
                w_wr     = 1'b1;
                w_upd_zn = 1'b1;
            end
            OP_CMP: begin
                w_res    = w_diff[DATA_W-1:0];
                w_nc     = w_diff[DATA_W];
                w_upd_zn = 1'b1;
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    assign w_nz = w_upd_zn ? (w_res == '0) : r_z;
    assign w_nn = w_upd_zn ? w_res[DATA_W-1] : r_n;

    // Branch conditions use the flags held before this WB
    assign w_take = (w_op == OP_JMP)
                  | ((w_op == OP_JZ) & r_z)
                  | ((w_op == OP_JC) & r_c);
    assign w_target = ADDR_W'(r_ir[7:0]);
    assign w_pc_inc = r_pc + ADDR_W'(1);

    always_comb begin
        w_next     = r_state;
        ins_req    = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (en_in) w_next = S_FETCH;
            end
            S_FETCH: begin
                ins_req = 1'b1;
                if (ins_valid) w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_WB;
            end
            S_WB: begin
                instr_done = 1'b1;
                if (w_op == OP_HALT) w_next = S_HALT;
                else if (en_in)      w_next = S_FETCH;
                else                 w_next = S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
            r_res   <= '0;
            r_wr    <= 1'b0;
            r_nz    <= 1'b0;
            r_nn    <= 1'b0;
            r_nc    <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && ins_valid) begin
                r_ir <= ins;
            end
            if (r_state == S_EXEC) begin
                r_res <= w_res;
                r_wr  <= w_wr;
                r_nz  <= w_nz;
                r_nn  <= w_nn;
                r_nc  <= w_nc;
            end
            if (r_state == S_WB) begin
                if (r_wr) r_regs[w_rd] <= r_res;
                r_z <= r_nz;
                r_n <= r_nn;
                r_c <= r_nc;
                if (w_op != OP_HALT) begin
                    r_pc <= w_take ? w_target : w_pc_inc;
                end
            end
        end
    end

    assign addr     = r_pc;
    assign flag_z   = r_z;
    assign flag_n   = r_n;
    assign flag_c   = r_c;
    assign dbg_data = r_regs[dbg_sel];

endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: vector, directed and random checks of cpu_core_param
// for a 16/16 instance and an 8/8 instance.
module tb_cpu_core_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic        ins_valid;
    logic [1:0]  dbg_sel;
    logic [15:0] ins;
    logic        ins_req;
    logic [15:0] addr;
    logic        instr_done;
    logic        halted;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic [15:0] dbg_data;

    logic        en8;
    logic        valid8;
    logic [1:0]  dbg_sel8;
    logic [15:0] ins8;
    logic        req8;
    logic [7:0]  addr8;
    logic        done8;
    logic        halted8;
    logic        z8;
    logic        n8;
    logic        c8;
    logic [7:0]  dbg8;

    logic [15:0] mem16 [256];
    logic [15:0] mem8  [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ins  = mem16[addr[7:0]];
    assign ins8 = mem8[addr8];

    cpu_core_param #(.DATA_W(16), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst), .en_in(en_in),
        .ins_req(ins_req), .addr(addr), .ins(ins),
        .ins_valid(ins_valid), .instr_done(instr_done),
        .halted(halted), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    cpu_core_param #(.DATA_W(8), .ADDR_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en_in(en8),
        .ins_req(req8), .addr(addr8), .ins(ins8),
        .ins_valid(valid8), .instr_done(done8),
        .halted(halted8), .flag_z(z8), .flag_n(n8),
        .flag_c(c8), .dbg_sel(dbg_sel8), .dbg_data(dbg8)
    );

    typedef struct {
        logic [15:0] ins;
        logic [15:0] at;
        logic [1:0]  ri;
        logic [15:0] val;
        logic [2:0]  znc;
        logic [15:0] nxt;
    } vec_t;

    vec_t tbl [23];

    // Architectural reference model
    int m_r [4];
    int m_pc;
    bit m_z, m_n, m_c;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within bound, expected one", nm);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en_in     = 1'b0;
        ins_valid = 1'b0;
        en8       = 1'b0;
        valid8    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (instr_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic wait_done8(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic wait_req(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ins_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic rd16(input logic [1:0] s, output logic [15:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    task automatic rd8(input logic [1:0] s, output logic [7:0] v);
        dbg_sel8 = s;
        #1;
        v = dbg8;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_pc = 0;
        m_z  = 0;
        m_n  = 0;
        m_c  = 0;
    endtask

    task automatic m_step(input logic [15:0] w);
        int op, rd, rs, a, b, r;
        bit wr, zn, zold, cold;
        op   = int'(w[15:12]);
        rd   = int'(w[11:10]);
        rs   = int'(w[9:8]);
        a    = m_r[rd];
        b    = (op % 2 == 1) ? m_r[rs] : int'(w[7:0]);
        wr   = 0;
        zn   = 0;
        r    = 0;
        zold = m_z;
        cold = m_c;
        case (op)
            0, 1: begin r = b; wr = 1; zn = 1; end
            2, 3: begin
                r = (a + b) & 'hFFFF; m_c = (a + b) > 'hFFFF;
                wr = 1; zn = 1;
            end
            4, 5: begin
                r = (a - b) & 'hFFFF; m_c = b > a;
                wr = 1; zn = 1;
            end
            6, 7: begin r = a & b; m_c = 0; wr = 1; zn = 1; end
            8, 9: begin r = a | b; m_c = 0; wr = 1; zn = 1; end
            13: begin r = (a - b) & 'hFFFF; m_c = b > a; zn = 1; end
            default: r = 0;
        endcase
        if (zn) begin
            m_z = (r == 0);
            m_n = ((r >> 15) & 1) == 1;
        end
        if (wr) m_r[rd] = r;
        if (op == 10 || (op == 11 && zold) || (op == 12 && cold))
            m_pc = int'(w[7:0]);
        else if (op != 15)
            m_pc = (m_pc + 1) & 'hFFFF;
    endtask

    initial begin
        bit ok;
        logic [15:0] v;
        logic [7:0]  v8;
        int cnt;

        tbl[0]  = '{16'h0458, 16'h00, 2'd1, 16'h0058, 3'b000, 16'h01};
        tbl[1]  = '{16'h0C29, 16'h01, 2'd3, 16'h0029, 3'b000, 16'h02};
        tbl[2]  = '{16'h5D46, 16'h02, 2'd3, 16'hFFD1, 3'b011, 16'h03};
        tbl[3]  = '{16'h7C46, 16'h03, 2'd3, 16'h0000, 3'b100, 16'h04};
        tbl[4]  = '{16'h081E, 16'h04, 2'd2, 16'h001E, 3'b000, 16'h05};
        tbl[5]  = '{16'h2846, 16'h05, 2'd2, 16'h0064, 3'b000, 16'h06};
        tbl[6]  = '{16'h0000, 16'h06, 2'd0, 16'h0000, 3'b100, 16'h07};
        tbl[7]  = '{16'h4001, 16'h07, 2'd0, 16'hFFFF, 3'b011, 16'h08};
        tbl[8]  = '{16'h2001, 16'h08, 2'd0, 16'h0000, 3'b101, 16'h09};
        tbl[9]  = '{16'h7C46, 16'h09, 2'd3, 16'h0000, 3'b100, 16'h0A};
        tbl[10] = '{16'hB020, 16'h0A, 2'd0, 16'h0000, 3'b100, 16'h20};
        tbl[11] = '{16'hC040, 16'h20, 2'd0, 16'h0000, 3'b100, 16'h21};
        tbl[12] = '{16'h4001, 16'h21, 2'd0, 16'hFFFF, 3'b011, 16'h22};
        tbl[13] = '{16'hC040, 16'h22, 2'd0, 16'hFFFF, 3'b011, 16'h40};
        tbl[14] = '{16'hB010, 16'h40, 2'd0, 16'hFFFF, 3'b011, 16'h41};
        tbl[15] = '{16'hD500, 16'h41, 2'd1, 16'h0058, 3'b100, 16'h42};
        tbl[16] = '{16'hA080, 16'h42, 2'd0, 16'hFFFF, 3'b100, 16'h80};
        tbl[17] = '{16'h1900, 16'h80, 2'd2, 16'h0058, 3'b000, 16'h81};
        tbl[18] = '{16'h8880, 16'h81, 2'd2, 16'h00D8, 3'b000, 16'h82};
        tbl[19] = '{16'h9C00, 16'h82, 2'd3, 16'hFFFF, 3'b010, 16'h83};
        tbl[20] = '{16'hE000, 16'h83, 2'd0, 16'hFFFF, 3'b010, 16'h84};
        tbl[21] = '{16'h3000, 16'h84, 2'd0, 16'hFFFE, 3'b011, 16'h85};
        tbl[22] = '{16'h0480, 16'h85, 2'd1, 16'h0080, 3'b001, 16'h86};

        dbg_sel  = 2'd0;
        dbg_sel8 = 2'd0;
        for (int i = 0; i < 256; i++) begin
            mem16[i] = 16'h0000;
            mem8[i]  = 16'h0000;
        end

        // Reset state
        do_reset();
        chk("rst_req", ins_req, 0);
        chk("rst_done", instr_done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", addr, 0);
        chk("rst_flags", {flag_z, flag_n, flag_c}, 0);
        for (int r = 0; r < 4; r++) begin
            rd16(r[1:0], v);
            chk($sformatf("rst_r%0d", r), v, 0);
        end
        chk("rst_addr8", addr8, 0);

        // Vector table
        for (int i = 0; i < 23; i++) mem16[tbl[i].at[7:0]] = tbl[i].ins;
        en_in     = 1'b1;
        ins_valid = 1'b1;
        for (int i = 0; i < 23; i++) begin
            wait_done($sformatf("v%0d_done", i), ok);
            if (!ok) break;
            chk($sformatf("v%0d_at", i), addr, tbl[i].at);
            @(negedge clk);
            rd16(tbl[i].ri, v);
            chk($sformatf("v%0d_val", i), v, tbl[i].val);
            chk($sformatf("v%0d_znc", i), {flag_z, flag_n, flag_c},
                tbl[i].znc);
            chk($sformatf("v%0d_nxt", i), addr, tbl[i].nxt);
        end

        // Wait states, then reset mid-FETCH
        for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
        mem16[0] = 16'h0458;
        do_reset();
        en_in = 1'b1;
        wait_req("ws_req", ok);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("ws%0d_req", i), ins_req, 1);
            chk($sformatf("ws%0d_addr", i), addr, 0);
            chk($sformatf("ws%0d_done", i), instr_done, 0);
        end
        ins_valid = 1'b1;
        wait_done("ws_done", ok);
        ins_valid = 1'b0;
        @(negedge clk);
        rd16(2'd1, v);
        chk("ws_r1", v, 16'h0058);
        chk("ws_fetch1_req", ins_req, 1);
        chk("ws_fetch1_addr", addr, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", ins_req, 0);
        chk("mid_rst_addr", addr, 0);
        rd16(2'd1, v);
        chk("mid_rst_r1", v, 0);
        rst = 1'b0;

        // HALT
        mem16[1] = 16'hF000;
        mem16[2] = 16'h0C29;
        do_reset();
        en_in     = 1'b1;
        ins_valid = 1'b1;
        wait_done("h_mov", ok);
        wait_done("h_halt", ok);
        chk("h_at", addr, 1);
        @(negedge clk);
        chk("h_halted", halted, 1);
        chk("h_req", ins_req, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(instr_done) + int'(ins_req);
        end
        chk("h_quiet", cnt, 0);
        chk("h_addr", addr, 1);
        chk("h_still", halted, 1);
        rd16(2'd3, v);
        chk("h_r3", v, 0);

        // en_in dropped during EXEC
        mem16[0] = 16'h0C29;
        mem16[1] = 16'h0458;
        do_reset();
        en_in     = 1'b1;
        ins_valid = 1'b1;
        wait_req("en_req", ok);
        @(negedge clk);
        en_in = 1'b0;
        wait_done("en_done", ok);
        @(negedge clk);
        rd16(2'd3, v);
        chk("en_r3", v, 16'h0029);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt += int'(ins_req) + int'(instr_done);
        end
        chk("en_idle", cnt, 0);
        chk("en_addr", addr, 1);
        en_in = 1'b1;
        wait_done("en_resume", ok);
        chk("en_res_at", addr, 1);
        @(negedge clk);
        rd16(2'd1, v);
        chk("en_r1", v, 16'h0058);
        chk("en_nxt", addr, 2);

        // 8-bit instance: SUB borrow and PC wrap
        mem8[0]     = 16'h0C29;
        mem8[1]     = 16'h0458;
        mem8[2]     = 16'h5D46;
        mem8[3]     = 16'hA0FF;
        mem8[8'hFF] = 16'hE000;
        do_reset();
        en8    = 1'b1;
        valid8 = 1'b1;
        for (int i = 0; i < 3; i++) wait_done8("d8_pre", ok);
        @(negedge clk);
        rd8(2'd3, v8);
        chk("d8_r3", v8, 8'hD1);
        chk("d8_znc", {z8, n8, c8}, 3'b011);
        wait_done8("d8_jmp", ok);
        @(negedge clk);
        chk("d8_ff", addr8, 8'hFF);
        wait_done8("d8_nop", ok);
        chk("d8_nop_at", addr8, 8'hFF);
        @(negedge clk);
        chk("d8_wrap", addr8, 8'h00);
        chk("d8_nop_znc", {z8, n8, c8}, 3'b011);
        en8 = 1'b0;

        // Random program against the reference model
        for (int i = 0; i < 256; i++) begin
            mem16[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        do_reset();
        m_reset();
        begin
            int retired;
            int idle;
            retired = 0;
            idle    = 0;
            while (retired < 200 && idle < 200) begin
                @(negedge clk);
                if (instr_done) begin
                    chk("rnd_at", addr, m_pc[15:0]);
                    m_step(mem16[m_pc[7:0]]);
                    retired++;
                    idle = 0;
                    @(negedge clk);
                    chk("rnd_pc", addr, m_pc[15:0]);
                    chk("rnd_znc", {flag_z, flag_n, flag_c},
                        {m_z, m_n, m_c});
                    for (int r = 0; r < 4; r++) begin
                        rd16(r[1:0], v);
                        chk($sformatf("rnd_r%0d", r), v, m_r[r][15:0]);
                    end
                end else begin
                    idle++;
                end
                ins_valid = ($urandom % 4) != 0;
                en_in     = ($urandom % 8) != 0;
            end
            if (idle >= 200) timeout("rnd_retire");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
